// File: rtl/random_led_sequencer_multi.sv
// -----------------------------------------------------------------------------
// random_led_sequencer_multi
//
// Lights one of NUM_LEDS LEDs, chosen from an external RNG, for ON_MS
// milliseconds. It then blanks all LEDs for GAP_MS milliseconds and repeats.
// The same index is never chosen twice in a row: a repeat is bumped to the
// next index, wrapping to 0. Player hits are classified as a correct hit or a
// miss, and correct hits advance a saturating score. Time is measured with an
// external ms timer, which this block enables and clears.
//
// Optional feature (macro RLS_DIFFICULTY_RAMP_EN): each correct hit shortens
// the on-time by STEP_MS, down to MIN_ON_MS. score_clr restores it to ON_MS.
// When the macro is undefined the on-time is the constant ON_MS.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous, active-low reset
//   enable         run the sequence while high; low forces IDLE
//   score_clr      synchronous score clear (wins over a same-cycle hit)
//   random_value   free-running RNG output
//   timer_value    external ms timer count
//   hit_valid      one-cycle hit strobe
//   hit_index      index the player hit
//   leds           one-hot LED drive
//   timer_enable   timer count enable
//   timer_reset    timer synchronous clear
//   active_index   currently selected index
//   hit_pulse      correct-hit strobe
//   miss_pulse     wrong-index-hit strobe
//   timeout_pulse  LED expired without a hit
//   score          saturating hit count
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module random_led_sequencer_multi #(
    parameter int NUM_LEDS  = 18,
    parameter int RAND_W    = 11,
    parameter int TIMER_W   = 11,
    parameter int ON_MS     = 500,
    parameter int GAP_MS    = 100,
    parameter int SCORE_W   = 8,
    parameter int STEP_MS   = 25,
    parameter int MIN_ON_MS = 150,
    localparam int IDX_W    = $clog2(NUM_LEDS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               score_clr,
    input  logic [RAND_W-1:0]  random_value,
    input  logic [TIMER_W-1:0] timer_value,
    input  logic               hit_valid,
    input  logic [IDX_W-1:0]   hit_index,
    output logic [NUM_LEDS-1:0] leds,
    output logic               timer_enable,
    output logic               timer_reset,
    output logic [IDX_W-1:0]   active_index,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic               timeout_pulse,
    output logic [SCORE_W-1:0] score
);

    // Elaboration-time parameter sanity check.
    if (NUM_LEDS < 2 || NUM_LEDS > 32 || ON_MS < 1 || STEP_MS < 0 ||
        MIN_ON_MS > ON_MS) begin : g_bad_params
        $error("random_led_sequencer_multi: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_ON,
        S_GAP
    } state_t;

    state_t               r_state, w_state_next;
    logic [NUM_LEDS-1:0]  r_leds, w_leds_next;
    logic                 r_timer_enable, w_timer_enable_next;
    logic                 r_timer_reset, w_timer_reset_next;
    logic [IDX_W-1:0]     r_active, w_active_next;
    logic [IDX_W-1:0]     r_last, w_last_next;
    logic                 r_last_valid, w_last_valid_next;
    logic                 r_hit, w_hit_next;
    logic                 r_miss, w_miss_next;
    logic                 r_timeout, w_timeout_next;
    logic [SCORE_W-1:0]   r_score, w_score_next;
    logic [TIMER_W-1:0]   r_on_time, w_on_time_next;
    logic                 w_score_inc;

    logic [IDX_W-1:0]     w_cand_raw;
    logic [IDX_W-1:0]     w_cand;
    logic [NUM_LEDS-1:0]  w_onehot;
    logic                 w_hit_ok;
    logic                 w_timer_fresh;

    // Candidate index, with the bump that avoids a back-to-back repeat.
    always_comb begin
        w_cand_raw = IDX_W'(32'(random_value) % NUM_LEDS);
        w_cand     = w_cand_raw;
        if (r_last_valid && (w_cand_raw == r_last)) begin
            w_cand = (w_cand_raw == IDX_W'(NUM_LEDS - 1)) ? '0 : w_cand_raw + IDX_W'(1);
        end
        w_onehot = NUM_LEDS'(1) << w_cand;
    end

    // An out-of-range hit_index can never equal active_index, so it is a miss.
    assign w_hit_ok = hit_valid && (hit_index == r_active);

    // While timer_reset is on the wire, timer_value still holds the previous
    // interval's count. Expiry comparisons ignore it until the clear has landed.
    assign w_timer_fresh = !r_timer_reset;

    // NOTE: every signal gets a default before the case statement, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        w_state_next        = r_state;
        w_leds_next         = r_leds;
        w_timer_enable_next = 1'b0;
        w_timer_reset_next  = 1'b0;
        w_active_next       = r_active;
        w_last_next         = r_last;
        w_last_valid_next   = r_last_valid;
        w_hit_next          = 1'b0;
        w_miss_next         = 1'b0;
        w_timeout_next      = 1'b0;
        w_score_inc         = 1'b0;

        if (!enable) begin
            w_state_next = S_IDLE;
            w_leds_next  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_leds_next  = '0;
                    w_state_next = S_SELECT;
                end
                S_SELECT: begin
                    // The LED is lit in the same update that latches the index.
                    w_active_next       = w_cand;
                    w_last_next         = w_cand;
                    w_last_valid_next   = 1'b1;
                    w_leds_next         = w_onehot;
                    w_timer_reset_next  = 1'b1;
                    w_timer_enable_next = 1'b1;
                    w_state_next        = S_ON;
                end
                S_ON: begin
                    w_timer_enable_next = 1'b1;
                    if (w_hit_ok) begin
                        // A correct hit beats a same-cycle expiry.
                        w_hit_next  = 1'b1;
                        w_score_inc = 1'b1;
                    end else begin
                        w_miss_next    = hit_valid;
                        w_timeout_next = w_timer_fresh && (timer_value >= r_on_time);
                    end
                    if (w_hit_next || w_timeout_next) begin
                        w_leds_next        = '0;
                        w_timer_reset_next = 1'b1;
                        w_state_next       = (GAP_MS == 0) ? S_SELECT : S_GAP;
                    end
                end
                S_GAP: begin
                    w_leds_next         = '0;
                    w_timer_enable_next = 1'b1;
                    if (w_timer_fresh && (timer_value >= TIMER_W'(GAP_MS))) begin
                        w_state_next = S_SELECT;
                    end
                end
                default: begin
                    w_leds_next  = '0;
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // A clear wins over a same-cycle increment; the score saturates at all-ones.
    always_comb begin
        w_score_next = r_score;
        if (score_clr) begin
            w_score_next = '0;
        end else if (w_score_inc && (r_score != '1)) begin
            w_score_next = r_score + SCORE_W'(1);
        end
    end

`ifdef RLS_DIFFICULTY_RAMP_EN
    always_comb begin
        w_on_time_next = r_on_time;
        if (score_clr) begin
            w_on_time_next = TIMER_W'(ON_MS);
        end else if (w_score_inc) begin
            w_on_time_next = (r_on_time >= TIMER_W'(MIN_ON_MS + STEP_MS))
                           ? r_on_time - TIMER_W'(STEP_MS)
                           : TIMER_W'(MIN_ON_MS);
        end
    end
`else
    always_comb begin
        w_on_time_next = r_on_time;
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only. Every register
    // here is control state, so all of them return to a known value on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_leds         <= '0;
            r_timer_enable <= 1'b0;
            r_timer_reset  <= 1'b1;
            r_active       <= '0;
            r_last         <= '0;
            r_last_valid   <= 1'b0;
            r_hit          <= 1'b0;
            r_miss         <= 1'b0;
            r_timeout      <= 1'b0;
            r_score        <= '0;
            r_on_time      <= TIMER_W'(ON_MS);
        end else begin
            r_state        <= w_state_next;
            r_leds         <= w_leds_next;
            r_timer_enable <= w_timer_enable_next;
            r_timer_reset  <= w_timer_reset_next;
            r_active       <= w_active_next;
            r_last         <= w_last_next;
            r_last_valid   <= w_last_valid_next;
            r_hit          <= w_hit_next;
            r_miss         <= w_miss_next;
            r_timeout      <= w_timeout_next;
            r_score        <= w_score_next;
            r_on_time      <= w_on_time_next;
        end
    end

    assign leds          = r_leds;
    assign timer_enable  = r_timer_enable;
    assign timer_reset   = r_timer_reset;
    assign active_index  = r_active;
    assign hit_pulse     = r_hit;
    assign miss_pulse    = r_miss;
    assign timeout_pulse = r_timeout;
    assign score         = r_score;

endmodule

// File: tb/tb_random_led_sequencer_multi.sv
// -----------------------------------------------------------------------------
// tb_random_led_sequencer_multi
//
// Directed bench for random_led_sequencer_multi with its default parameters
// (18 LEDs, 500 ms on-time, 100 ms gap, 8-bit score). The external ms timer is
// modelled as a counter that advances once per clock while enabled and reads
// 0 on the cycle after timer_reset is sampled. Inputs are driven 1 ns after
// the rising edge, and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_random_led_sequencer_multi;

    localparam int N       = 18;
    localparam int ON_MS   = 500;
    localparam int GAP_MS  = 100;
    localparam int STEP_MS = 25;
    localparam int MIN_ON  = 150;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        score_clr;
    logic [10:0] random_value;
    logic [10:0] timer_value;
    logic        hit_valid;
    logic [4:0]  hit_index;
    logic [N-1:0] leds;
    logic        timer_enable;
    logic        timer_reset;
    logic [4:0]  active_index;
    logic        hit_pulse;
    logic        miss_pulse;
    logic        timeout_pulse;
    logic [7:0]  score;

    int n_pass   = 0;
    int n_checks = 0;

    // Bench-side model state.
    int m_last  = -1;
    int m_score = 0;
    int m_on    = ON_MS;
    int prev_tv = 0;

    random_led_sequencer_multi dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .score_clr     (score_clr),
        .random_value  (random_value),
        .timer_value   (timer_value),
        .hit_valid     (hit_valid),
        .hit_index     (hit_index),
        .leds          (leds),
        .timer_enable  (timer_enable),
        .timer_reset   (timer_reset),
        .active_index  (active_index),
        .hit_pulse     (hit_pulse),
        .miss_pulse    (miss_pulse),
        .timeout_pulse (timeout_pulse),
        .score         (score)
    );

    always #5 clk = ~clk;

    // External ms timer model.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)          timer_value <= '0;
        else if (timer_reset)  timer_value <= '0;
        else if (timer_enable) timer_value <= timer_value + 11'd1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    // Index choice with repeat avoidance.
    function automatic int pick(input int rv);
        int c;
        c = rv % N;
        if (m_last >= 0 && c == m_last) c = (c + 1) % N;
        return c;
    endfunction

    function automatic int on_after_hit(input int on);
`ifdef RLS_DIFFICULTY_RAMP_EN
        return (on - STEP_MS >= MIN_ON) ? on - STEP_MS : MIN_ON;
`else
        return on;
`endif
    endfunction

    task automatic tick();
        prev_tv = int'(timer_value);
        @(posedge clk);
        #1;
    endtask

    task automatic strobe_hit(input int idx);
        hit_index = 5'(idx);
        hit_valid = 1'b1;
        tick();
        hit_valid = 1'b0;
    endtask

    task automatic wait_lit(output int cycles, output bit ok);
        cycles = 0;
        ok     = 1'b0;
        while (cycles < 400) begin
            tick();
            cycles++;
            if (leds !== '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_timeout(output bit ok);
        int c;
        ok = 1'b0;
        for (c = 0; c < 800; c++) begin
            tick();
            if (timeout_pulse === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; score_clr = 1'b0;
        random_value = '0; hit_valid = 1'b0; hit_index = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (leds !== '0 || timer_enable !== 1'b0 || timer_reset !== 1'b1)
            $display("FAIL reset_ctrl: leds=%h ten=%b trst=%b expected leds=0 ten=0 trst=1",
                     leds, timer_enable, timer_reset);
        else n_pass++;
        n_checks++;
        if (active_index !== 5'd0 || score !== 8'd0 ||
            {hit_pulse, miss_pulse, timeout_pulse} !== 3'b000)
            $display("FAIL reset_state: idx=%0d score=%0d pulses=%b expected 0 0 000",
                     active_index, score, {hit_pulse, miss_pulse, timeout_pulse});
        else n_pass++;
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (leds !== '0 || timer_reset !== 1'b0 || timer_enable !== 1'b0)
            $display("FAIL idle_after_reset: leds=%h trst=%b ten=%b expected 0 0 0",
                     leds, timer_reset, timer_enable);
        else n_pass++;
    endtask

    task automatic test_start();
        int rst_cnt;
        int exp;
        logic [N-1:0] exp_leds;
        m_last = -1;
        random_value = 11'd40;
        enable = 1'b1;
        rst_cnt = 0;
        tick();                        // IDLE -> SELECT
        rst_cnt += int'(timer_reset);
        n_checks++;
        if (leds !== '0)
            $display("FAIL start_no_stale: leds=%h expected 0", leds);
        else n_pass++;
        tick();                        // SELECT -> ON
        rst_cnt += int'(timer_reset);
        exp = pick(40);                // 40 % 18 = 4
        m_last = exp;
        exp_leds = N'(1) << exp;
        n_checks++;
        if (leds !== exp_leds || active_index !== 5'(exp))
            $display("FAIL start_index: leds=%h idx=%0d expected leds=%h idx=%0d",
                     leds, active_index, exp_leds, exp);
        else n_pass++;
        tick();
        rst_cnt += int'(timer_reset);
        n_checks++;
        if (rst_cnt != 1 || leds !== exp_leds)
            $display("FAIL start_timer_reset: pulses=%0d leds=%h expected 1 pulse leds=%h",
                     rst_cnt, leds, exp_leds);
        else n_pass++;
    endtask

    task automatic test_miss();
        logic [N-1:0] exp_leds;
        exp_leds = N'(1) << 4;
        strobe_hit(3);
        n_checks++;
        if (miss_pulse !== 1'b1 || hit_pulse !== 1'b0 || leds !== exp_leds || score !== 8'd0)
            $display("FAIL miss_wrong_idx: miss=%b hit=%b leds=%h score=%0d expected 1 0 %h 0",
                     miss_pulse, hit_pulse, leds, exp_leds, score);
        else n_pass++;
        tick();
        n_checks++;
        if (miss_pulse !== 1'b0)
            $display("FAIL miss_one_cycle: miss=%b expected 0", miss_pulse);
        else n_pass++;
        strobe_hit(20);                // out-of-range index
        n_checks++;
        if (miss_pulse !== 1'b1 || leds !== exp_leds)
            $display("FAIL miss_out_of_range: miss=%b leds=%h expected 1 %h",
                     miss_pulse, leds, exp_leds);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        int cyc;
        int exp;
        logic [N-1:0] exp_leds;
        wait_timeout(ok);
        n_checks++;
        if (!ok || prev_tv != m_on || leds !== '0 || hit_pulse !== 1'b0)
            $display("FAIL timeout_fire: seen=%0d at_tv=%0d leds=%h hit=%b expected 1 %0d 0 0",
                     ok, prev_tv, leds, hit_pulse, m_on);
        else n_pass++;
        tick();
        n_checks++;
        if (timeout_pulse !== 1'b0)
            $display("FAIL timeout_one_cycle: timeout=%b expected 0", timeout_pulse);
        else n_pass++;
        // Gap: 1 cycle while the clear lands, counts 0..100, then SELECT, then ON.
        wait_lit(cyc, ok);
        n_checks++;
        if (!ok || cyc + 1 != GAP_MS + 3)
            $display("FAIL gap_length: lit=%0d cycles=%0d expected 1 %0d",
                     ok, cyc + 1, GAP_MS + 3);
        else n_pass++;
        exp = pick(40);                // repeat of 4 -> 5
        m_last = exp;
        exp_leds = N'(1) << exp;
        n_checks++;
        if (active_index !== 5'd5 || leds !== exp_leds)
            $display("FAIL repeat_bump: idx=%0d leds=%h expected 5 %h",
                     active_index, leds, exp_leds);
        else n_pass++;
    endtask

    task automatic test_hit_and_wrap();
        bit ok;
        int cyc;
        int exp;
        strobe_hit(5);
        m_score = 1;
        m_on = on_after_hit(m_on);
        n_checks++;
        if (hit_pulse !== 1'b1 || miss_pulse !== 1'b0 || leds !== '0 || score !== 8'd1)
            $display("FAIL hit_correct: hit=%b miss=%b leds=%h score=%0d expected 1 0 0 1",
                     hit_pulse, miss_pulse, leds, score);
        else n_pass++;
        random_value = 11'd35;         // 35 % 18 = 17
        wait_lit(cyc, ok);
        exp = pick(35);
        m_last = exp;
        n_checks++;
        if (!ok || active_index !== 5'd17)
            $display("FAIL select_17: lit=%0d idx=%0d expected 1 17", ok, active_index);
        else n_pass++;
        strobe_hit(17);
        m_score = 2;
        m_on = on_after_hit(m_on);
        wait_lit(cyc, ok);
        exp = pick(35);                // repeat of 17 wraps to 0
        m_last = exp;
        n_checks++;
        if (!ok || active_index !== 5'd0 || leds !== N'(1) || score !== 8'd2)
            $display("FAIL repeat_wrap: idx=%0d leds=%h score=%0d expected 0 1 2",
                     active_index, leds, score);
        else n_pass++;
    endtask

    task automatic test_hit_at_expiry();
        int c;
        c = 0;
        while (int'(timer_value) != m_on && c < 800) begin
            tick();
            c++;
        end
        n_checks++;
        if (int'(timer_value) != m_on || timeout_pulse !== 1'b0)
            $display("FAIL expiry_reach: tv=%0d timeout=%b expected %0d 0",
                     timer_value, timeout_pulse, m_on);
        else n_pass++;
        strobe_hit(0);
        m_score = 3;
        m_on = on_after_hit(m_on);
        n_checks++;
        if (hit_pulse !== 1'b1 || timeout_pulse !== 1'b0 || score !== 8'd3)
            $display("FAIL hit_beats_expiry: hit=%b timeout=%b score=%0d expected 1 0 3",
                     hit_pulse, timeout_pulse, score);
        else n_pass++;
    endtask

    task automatic test_saturation();
        bit ok;
        int cyc;
        int exp;
        int bad;
        int i;
        bad = 0;
        i = 0;
        while (m_score < 255) begin
            random_value = 11'((i * 7 + 3) % 2048);
            wait_lit(cyc, ok);
            exp = pick((i * 7 + 3) % 2048);
            m_last = exp;
            if (!ok || active_index !== 5'(exp)) bad++;
            strobe_hit(exp);
            m_score++;
            m_on = on_after_hit(m_on);
            i++;
        end
        n_checks++;
        if (bad != 0 || score !== 8'd255)
            $display("FAIL score_reach_max: bad_rounds=%0d score=%0d expected 0 255",
                     bad, score);
        else n_pass++;
        random_value = 11'd100;        // 100 % 18 = 10
        wait_lit(cyc, ok);
        exp = pick(100);
        m_last = exp;
        strobe_hit(exp);
        m_on = on_after_hit(m_on);
        n_checks++;
        if (hit_pulse !== 1'b1 || score !== 8'd255)
            $display("FAIL score_saturate: hit=%b score=%0d expected 1 255", hit_pulse, score);
        else n_pass++;
    endtask

    task automatic test_enable_drop_and_clear();
        bit ok;
        int cyc;
        int exp;
        random_value = 11'd7;
        wait_lit(cyc, ok);
        exp = pick(7);
        m_last = exp;
        enable = 1'b0;
        tick();
        n_checks++;
        if (leds !== '0 || timer_enable !== 1'b0 || score !== 8'd255 ||
            {hit_pulse, miss_pulse, timeout_pulse} !== 3'b000)
            $display("FAIL enable_drop: leds=%h ten=%b score=%0d pulses=%b expected 0 0 255 000",
                     leds, timer_enable, score, {hit_pulse, miss_pulse, timeout_pulse});
        else n_pass++;
        tick();
        // Re-enable with the RNG pointing at the retained last index.
        random_value = 11'(m_last);
        enable = 1'b1;
        tick();
        tick();
        exp = pick(m_last);
        m_last = exp;
        n_checks++;
        if (active_index !== 5'(exp) || leds !== (N'(1) << exp))
            $display("FAIL last_idx_retained: idx=%0d expected %0d", active_index, exp);
        else n_pass++;
        score_clr = 1'b1;
        strobe_hit(exp);
        score_clr = 1'b0;
        m_score = 0;
        m_on = ON_MS;
        n_checks++;
        if (score !== 8'd0 || hit_pulse !== 1'b1)
            $display("FAIL clear_beats_hit: score=%0d hit=%b expected 0 1", score, hit_pulse);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        bit ok;
        int cyc;
        int exp;
        random_value = 11'd2;
        wait_lit(cyc, ok);
        exp = pick(2);
        m_last = exp;
        strobe_hit(exp);
        random_value = 11'd9;
        wait_lit(cyc, ok);
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (leds !== '0 || timer_reset !== 1'b1 || timer_enable !== 1'b0 ||
            score !== 8'd0 || active_index !== 5'd0)
            $display("FAIL async_reset: leds=%h trst=%b ten=%b score=%0d idx=%0d expected 0 1 0 0 0",
                     leds, timer_reset, timer_enable, score, active_index);
        else n_pass++;
        @(posedge clk);
        #1;
        m_last = -1;
        m_score = 0;
        m_on = ON_MS;
        reset_n = 1'b1;
    endtask

    task automatic test_ramp();
        bit ok;
        int cyc;
        int exp;
        for (int k = 0; k < 15; k++) begin
            random_value = 11'(k * 5 + 1);
            wait_lit(cyc, ok);
            exp = pick(k * 5 + 1);
            m_last = exp;
            strobe_hit(exp);
            m_score++;
            m_on = on_after_hit(m_on);
        end
        random_value = 11'd33;
        wait_lit(cyc, ok);
        m_last = pick(33);
        wait_timeout(ok);
        n_checks++;
        if (!ok || prev_tv != m_on || score !== 8'(m_score))
            $display("FAIL ontime_after_hits: seen=%0d at_tv=%0d score=%0d expected 1 %0d %0d",
                     ok, prev_tv, score, m_on, m_score);
        else n_pass++;
        score_clr = 1'b1;
        tick();
        score_clr = 1'b0;
        m_score = 0;
        m_on = ON_MS;
        wait_lit(cyc, ok);
        m_last = pick(33);
        wait_timeout(ok);
        n_checks++;
        if (!ok || prev_tv != ON_MS || score !== 8'd0)
            $display("FAIL ontime_restored: seen=%0d at_tv=%0d score=%0d expected 1 %0d 0",
                     ok, prev_tv, score, ON_MS);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_miss();
        test_timeout();
        test_hit_and_wrap();
        test_hit_at_expiry();
        test_saturation();
        test_enable_drop_and_clear();
        test_async_reset();
        test_ramp();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
